// File: rtl/spart_echo_system.sv
// Serial echo subsystem: a SPART (UART with a register bus) plus a driver that programs the baud
// divisor from br_cfg and re-sends every received byte; the start bit leaves 4 clocks after rda rises.

module spart (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs_i,
  input  logic       iorw_i,
  input  logic [1:0] ioaddr_i,
  input  logic [7:0] bus_wr_i,
  output logic [7:0] bus_rd_o,
  output logic       bus_oe_o,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic [7:0] rx_data_o,
  output logic       rx_strobe_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

  logic [15:0] db_q;
  logic        rxd_s1_q, rxd_s2_q, rxd_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_buf_q;
  logic        rda_q, rx_strobe_q, rx_done;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [8:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        tbr;
  logic        wr_tx, rd_rx, wr_lo, wr_hi;

  assign wr_tx = iocs_i && !iorw_i && (ioaddr_i == 2'b00);
  assign rd_rx = iocs_i &&  iorw_i && (ioaddr_i == 2'b00);
  assign wr_lo = iocs_i && !iorw_i && (ioaddr_i == 2'b10);
  assign wr_hi = iocs_i && !iorw_i && (ioaddr_i == 2'b11);
  assign tbr   = (tx_state_q == TX_IDLE);

  assign bus_oe_o    = iocs_i && iorw_i;
  assign txd_o       = txd_q;
  assign rx_data_o   = rx_buf_q;
  assign rx_strobe_o = rx_strobe_q;

  always_comb begin
    bus_rd_o = 8'h00;
    case (ioaddr_i)
      2'b00:   bus_rd_o = rx_buf_q;
      2'b01:   bus_rd_o = {6'b0, tbr, rda_q};
      default: bus_rd_o = 8'h00;
    endcase
  end

  // Receiver: half-period delay from the falling edge puts every later sample at mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_cnt_d   = {1'b0, db_q[15:1]};
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rxd_s2_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d   = db_q;
          rx_bit_d   = 3'd0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = db_q;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_done    = rxd_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Transmitter: txd is registered, so the start bit appears the cycle after the write.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (wr_tx) begin
          txd_d      = 1'b0;
          tx_shift_d = {1'b1, bus_wr_i};
          tx_cnt_d   = db_q;
          tx_bit_d   = 4'd0;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_cnt_q != 16'd0) begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end else if (tx_bit_q == 4'd9) begin
          tx_state_d = TX_IDLE;
        end else begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
          tx_cnt_d   = db_q;
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q        <= '0;
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_buf_q    <= '0;
      rda_q       <= 1'b0;
      rx_strobe_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
    end else begin
      rxd_s1_q    <= rxd_i;
      rxd_s2_q    <= rxd_s1_q;
      rxd_prev_q  <= rxd_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_strobe_q <= rx_done;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
      // A byte completing in the same cycle as a buffer read keeps rda set.
      if (rx_done) begin
        rx_buf_q <= rx_shift_q;
        rda_q    <= 1'b1;
      end else if (rd_rx) begin
        rda_q    <= 1'b0;
      end
      if (wr_lo) db_q[7:0]  <= bus_wr_i;
      if (wr_hi) db_q[15:8] <= bus_wr_i;
    end
  end

endmodule

module spart_driver #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg_i,
  input  logic [7:0] bus_rd_i,
  output logic       iocs_o,
  output logic       iorw_o,
  output logic [1:0] ioaddr_o,
  output logic [7:0] bus_wr_o
);

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, READ, WAIT_TBR, WRITE} drv_state_e;

  localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / 4800 - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / 9600 - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / 19200 - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ / 38400 - 1);

  function automatic logic [15:0] divisor(input logic [1:0] sel);
    logic [15:0] d;
    d = DIV_4800;
    case (sel)
      2'b00: d = DIV_4800;
      2'b01: d = DIV_9600;
      2'b10: d = DIV_19200;
      2'b11: d = DIV_38400;
      default: d = DIV_4800;
    endcase
    return d;
  endfunction

  drv_state_e  state_q, state_d;
  logic [1:0]  br_q, cfg_q, cfg_d;
  logic [7:0]  echo_q, echo_d;
  logic [15:0] div_new, div_cur;

  // cfg_q holds the setting being programmed so both halves come from the same table entry.
  assign div_new = divisor(br_q);
  assign div_cur = divisor(cfg_q);

  // Bus outputs depend only on state so the databus read path never loops back into them.
  always_comb begin
    iocs_o   = 1'b1;
    iorw_o   = 1'b1;
    ioaddr_o = 2'b01;
    bus_wr_o = 8'h00;
    case (state_q)
      CFG_LO: begin
        iorw_o   = 1'b0;
        ioaddr_o = 2'b10;
        bus_wr_o = div_new[7:0];
      end
      CFG_HI: begin
        iorw_o   = 1'b0;
        ioaddr_o = 2'b11;
        bus_wr_o = div_cur[15:8];
      end
      READ: ioaddr_o = 2'b00;
      WRITE: begin
        iorw_o   = 1'b0;
        ioaddr_o = 2'b00;
        bus_wr_o = echo_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    echo_d  = echo_q;
    case (state_q)
      CFG_LO: begin
        cfg_d   = br_q;
        state_d = CFG_HI;
      end
      CFG_HI: state_d = IDLE;
      IDLE: begin
        if (br_q != cfg_q)    state_d = CFG_LO;
        else if (bus_rd_i[0]) state_d = READ;
      end
      READ: begin
        echo_d  = bus_rd_i;
        state_d = WAIT_TBR;
      end
      WAIT_TBR: if (bus_rd_i[1]) state_d = WRITE;
      WRITE:    state_d = IDLE;
      default:  state_d = CFG_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CFG_LO;
      br_q    <= 2'b00;
      cfg_q   <= 2'b00;
      echo_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      br_q    <= br_cfg_i;
      cfg_q   <= cfg_d;
      echo_q  <= echo_d;
    end
  end

endmodule

module spart_echo_system #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_strobe
);

  logic       iocs, iorw, spart_oe;
  logic [1:0] ioaddr;
  logic [7:0] databus, spart_rd, drv_wr;

  // On-chip bus resolved as a mux: the SPART owns it during reads, the driver otherwise.
  assign databus = spart_oe ? spart_rd : drv_wr;

  spart u_spart (
    .clk         (clk),
    .rst         (rst),
    .iocs_i      (iocs),
    .iorw_i      (iorw),
    .ioaddr_i    (ioaddr),
    .bus_wr_i    (databus),
    .bus_rd_o    (spart_rd),
    .bus_oe_o    (spart_oe),
    .rxd_i       (rxd),
    .txd_o       (txd),
    .rx_data_o   (rx_data),
    .rx_strobe_o (rx_strobe)
  );

  spart_driver #(.CLK_FREQ(CLK_FREQ)) u_driver (
    .clk      (clk),
    .rst      (rst),
    .br_cfg_i (br_cfg),
    .bus_rd_i (databus),
    .iocs_o   (iocs),
    .iorw_o   (iorw),
    .ioaddr_o (ioaddr),
    .bus_wr_o (drv_wr)
  );

endmodule

// File: tb/tb_spart_echo_system.sv
// Directed echo tests with queue scoreboards; a scaled clock keeps frames short.
module tb_spart_echo_system;

  localparam int CLK_FREQ = 960000;  // divisors 199/99/49/24, i.e. 200/100/50/25 clocks per bit

  logic       clk = 1'b0;
  logic       rst, rxd;
  logic [1:0] br_cfg, br_cfg50;
  logic       txd, rx_strobe, txd50, rx_strobe50;
  logic [7:0] rx_data, rx_data50;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_period = 200;
  int last_start_w = 0;
  int last_latency = 0;
  int last_strobe_cyc = 0;
  bit mon_busy = 1'b0;
  logic prev_strobe = 1'b0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  int div50[4] = '{10415, 5207, 2603, 1301};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spart_echo_system #(.CLK_FREQ(CLK_FREQ)) u_dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rxd(rxd),
    .txd(txd), .rx_data(rx_data), .rx_strobe(rx_strobe)
  );

  spart_echo_system u_dut50 (
    .clk(clk), .rst(rst), .br_cfg(br_cfg50), .rxd(1'b1),
    .txd(txd50), .rx_data(rx_data50), .rx_strobe(rx_strobe50)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int p, input logic stop_bit);
    rxd = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (p) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (p) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_echo(input logic [7:0] b, input int p);
    rx_exp_q.push_back(b);
    tx_exp_q.push_back(b);
    send_byte(b, p, 1'b1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: %0d rx / %0d tx bytes outstanding after %0d cycles, required 0",
               name, rx_exp_q.size(), tx_exp_q.size(), n);
      rx_exp_q.delete();
      tx_exp_q.delete();
    end
  endtask

  // Receive-side monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_strobe === 1'b1) begin
        last_strobe_cyc = cyc;
        check("rx_strobe_width", {31'b0, prev_strobe}, 32'd0);
        if (rx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte %02h expected none", rx_data);
        end else begin
          check("rx_data", {24'b0, rx_data}, {24'b0, rx_exp_q.pop_front()});
        end
      end
      prev_strobe = rx_strobe;
    end
  end

  // Transmit-side monitor: every cycle of the frame is compared against the ideal waveform.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin : frame_blk
        int p, first_bad, run, b;
        logic [9:0] frame;
        logic [7:0] exp_b, got_b;
        bit ok, aborted, has_exp, in_run;
        mon_busy = 1'b1;
        p = tx_period;
        last_latency = cyc - last_strobe_cyc;
        has_exp = (tx_exp_q.size() != 0);
        exp_b = has_exp ? tx_exp_q.pop_front() : 8'h00;
        frame = {1'b1, exp_b, 1'b0};
        ok = 1'b1; aborted = 1'b0; in_run = 1'b1;
        first_bad = -1; run = 0; got_b = 8'h00;
        for (int i = 0; i < 10 * p; i++) begin
          if (i > 0) @(negedge clk);
          if (rst === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (txd !== frame[i / p]) begin
            if (ok) first_bad = i;
            ok = 1'b0;
          end
          if (in_run && txd === 1'b0) run++;
          else in_run = 1'b0;
          b = i / p;
          if ((i % p) == p / 2 && b >= 1 && b <= 8) got_b[b - 1] = txd;
        end
        last_start_w = run;
        if (!aborted) begin
          checks++;
          if (!has_exp) begin
            errors++;
            $display("FAIL tx_unexpected: got byte %02h expected none", got_b);
          end else if (!ok) begin
            errors++;
            $display("FAIL tx_frame: got byte %02h (first wrong cycle %0d) expected byte %02h at %0d clk/bit",
                     got_b, first_bad, exp_b, p);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    string hw;
    int low_cnt;
    hw = "HELLOWORLD";
    rst = 1'b1; rxd = 1'b1; br_cfg = 2'b00; br_cfg50 = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_txd", {31'b0, txd}, 32'd1);
    check("reset_rx_data", {24'b0, rx_data}, 32'd0);
    check("reset_rx_strobe", {31'b0, rx_strobe}, 32'd0);
    check("reset_tbr", {31'b0, u_dut.u_spart.tbr}, 32'd1);
    check("reset_rda", {31'b0, u_dut.u_spart.rda_q}, 32'd0);
    check("reset_db", {16'b0, u_dut.u_spart.db_q}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("db_4800", {16'b0, u_dut.u_spart.db_q}, 32'd199);
    check("db50_4800", {16'b0, u_dut50.u_spart.db_q}, 32'd10415);
    for (int s = 1; s < 4; s++) begin
      br_cfg50 = 2'(s);
      repeat (10) @(negedge clk);
      check($sformatf("db50_cfg%0d", s), {16'b0, u_dut50.u_spart.db_q}, div50[s]);
    end

    // 'H' at 4800 baud, plus echo latency from rda.
    send_echo(8'h48, 200);
    drain("echo_48", 6000);
    checks++;
    if (last_latency < 1 || last_latency > 6) begin
      errors++;
      $display("FAIL echo_latency: got %0d clocks, required 1..6", last_latency);
    end

    // Reset in the middle of an echoed frame; br_cfg changes while reset is held.
    send_echo(8'h5A, 200);
    repeat (600) @(negedge clk);
    check("tbr_busy_mid_frame", {31'b0, u_dut.u_spart.tbr}, 32'd0);
    check("rx_data_before_reset", {24'b0, rx_data}, 32'h5A);
    br_cfg = 2'b01;
    rst = 1'b1;
    #1;
    check("midframe_reset_txd", {31'b0, txd}, 32'd1);
    check("midframe_reset_tbr", {31'b0, u_dut.u_spart.tbr}, 32'd1);
    check("midframe_reset_rda", {31'b0, u_dut.u_spart.rda_q}, 32'd0);
    check("midframe_reset_rx_data", {24'b0, rx_data}, 32'd0);
    check("midframe_reset_rx_strobe", {31'b0, rx_strobe}, 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    rx_exp_q.delete();
    tx_exp_q.delete();
    tx_period = 100;
    repeat (12) @(negedge clk);
    check("db_9600_after_reset", {16'b0, u_dut.u_spart.db_q}, 32'd99);
    send_echo(8'h3C, 100);
    drain("echo_3c", 3000);

    // Framing error: no strobe, no echo, buffer and rda untouched; next byte is fine.
    send_byte(8'h55, 100, 1'b0);
    repeat (200) @(negedge clk);
    check("framing_rda", {31'b0, u_dut.u_spart.rda_q}, 32'd0);
    check("framing_rx_data", {24'b0, rx_data}, 32'h3C);
    send_echo(8'hA3, 100);
    drain("echo_a3_after_framing", 3000);

    // Quarter-bit glitch on idle line.
    rxd = 1'b0;
    repeat (25) @(negedge clk);
    rxd = 1'b1;
    low_cnt = 0;
    repeat (2000) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    check("glitch_txd_low_cycles", low_cnt, 32'd0);
    check("glitch_rda", {31'b0, u_dut.u_spart.rda_q}, 32'd0);
    check("glitch_rx_data", {24'b0, rx_data}, 32'hA3);

    // Back-to-back stream at 38400.
    br_cfg = 2'b11;
    tx_period = 25;
    repeat (10) @(negedge clk);
    check("db_38400", {16'b0, u_dut.u_spart.db_q}, 32'd24);
    for (int i = 0; i < hw.len(); i++) send_echo(hw[i], 25);
    drain("echo_helloworld", 1500);

    // 4800 -> 19200 while idle; measure the echoed start bit.
    br_cfg = 2'b00;
    repeat (10) @(negedge clk);
    check("db_back_to_4800", {16'b0, u_dut.u_spart.db_q}, 32'd199);
    br_cfg = 2'b10;
    tx_period = 50;
    repeat (10) @(negedge clk);
    check("db_19200", {16'b0, u_dut.u_spart.db_q}, 32'd49);
    send_echo(8'hA3, 50);
    drain("echo_a3_19200", 1500);
    check("start_bit_width_19200", last_start_w, 32'd50);

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
